// File: rtl/wav_buffer_filler.sv
// WAV stream front end: validates the canonical 44-byte header, publishes the format,
// then streams PCM bytes into alternating halves of the codec's ping-pong sample RAM.
module wav_buffer_filler #(
  parameter int BUFFER_SIZE_BYTES = 512,
  parameter int BUFFER_ADDR_BITS  = 9,
  parameter int HEADER_BYTES      = 44
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  src_data_i,
  input  logic                        src_valid_i,
  input  logic                        src_last_i,
  output logic                        src_ready_o,
  output logic [31:0]                 wav_info_sampling_rate_o,
  output logic [7:0]                  wav_info_audio_channels_o,
  output logic                        wav_info_valid_o,
  output logic                        wav_header_error_o,
  output logic                        fill_buffer_we_o,
  output logic                        fill_buffer_sel_o,
  output logic [BUFFER_ADDR_BITS-1:0] fill_buffer_addr_o,
  output logic [7:0]                  fill_buffer_data_o,
  input  logic                        codec_buffer_empty_i,
  output logic                        codec_buffer_empty_ack_o,
  output logic                        codec_buffer_filled_o,
  output logic                        play_done_o
);

  typedef enum logic [2:0] {
    S_HEADER, S_WAIT_EMPTY, S_FILL, S_PAD, S_FULL, S_DONE, S_ERROR
  } state_t;

  localparam logic [BUFFER_ADDR_BITS-1:0] LAST_ADDR = BUFFER_ADDR_BITS'(BUFFER_SIZE_BYTES - 1);
  localparam logic [BUFFER_ADDR_BITS-1:0] ADDR_ONE  = BUFFER_ADDR_BITS'(1);
  localparam logic [5:0]                  LAST_HDR  = 6'(HEADER_BYTES - 1);

  state_t                      state_q, state_d;
  logic [5:0]                  hdr_cnt_q, hdr_cnt_d;
  logic [BUFFER_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic                        last_buf_q, last_buf_d;
  logic                        ready_q, ready_d;
  logic [31:0]                 rate_q, rate_d;
  logic [7:0]                  chan_q, chan_d;
  logic                        info_valid_q, info_valid_d;
  logic                        hdr_err_q, hdr_err_d;
  logic                        we_q, we_d;
  logic                        sel_q, sel_d;
  logic [BUFFER_ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]                  data_q, data_d;
  logic                        ack_q, ack_d;
  logic                        filled_q, filled_d;
  logic                        done_q, done_d;

  logic accept;
  logic respond;
  logic at_last_addr;
  logic hdr_ok;

  assign accept       = src_valid_i && ready_q;
  assign at_last_addr = (wr_addr_q == LAST_ADDR);
  // In FULL the request is only honoured once the filled flag has actually been published.
  assign respond      = codec_buffer_empty_i &&
                        ((state_q == S_WAIT_EMPTY) || ((state_q == S_FULL) && filled_q));

  always_comb begin
    hdr_ok = 1'b1;
    case (hdr_cnt_q)
      6'd0:        hdr_ok = (src_data_i == 8'h52);
      6'd1:        hdr_ok = (src_data_i == 8'h49);
      6'd2, 6'd3:  hdr_ok = (src_data_i == 8'h46);
      6'd8:        hdr_ok = (src_data_i == 8'h57);
      6'd9:        hdr_ok = (src_data_i == 8'h41);
      6'd10:       hdr_ok = (src_data_i == 8'h56);
      6'd11:       hdr_ok = (src_data_i == 8'h45);
      6'd22:       hdr_ok = (src_data_i == 8'd1) || (src_data_i == 8'd2);
      6'd23, 6'd35: hdr_ok = (src_data_i == 8'h00);
      6'd34:       hdr_ok = (src_data_i == 8'h10);
      default:     hdr_ok = 1'b1;
    endcase
  end

  // NOTE: synchronous reset clears only control/output flops; there is no storage array to clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HEADER;
      hdr_cnt_q    <= '0;
      wr_addr_q    <= '0;
      last_buf_q   <= 1'b0;
      ready_q      <= 1'b0;
      rate_q       <= '0;
      chan_q       <= '0;
      info_valid_q <= 1'b0;
      hdr_err_q    <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      ack_q        <= 1'b0;
      filled_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      wr_addr_q    <= wr_addr_d;
      last_buf_q   <= last_buf_d;
      ready_q      <= ready_d;
      rate_q       <= rate_d;
      chan_q       <= chan_d;
      info_valid_q <= info_valid_d;
      hdr_err_q    <= hdr_err_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      ack_q        <= ack_d;
      filled_q     <= filled_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_HEADER: begin
        if (accept) begin
          if (!hdr_ok || src_last_i)     state_d = S_ERROR;
          else if (hdr_cnt_q == LAST_HDR) state_d = S_WAIT_EMPTY;
        end
      end
      S_WAIT_EMPTY, S_FULL: begin
        if (respond) state_d = last_buf_q ? S_DONE : S_FILL;
      end
      S_FILL: begin
        if (accept) begin
          if (at_last_addr)    state_d = S_FULL;
          else if (src_last_i) state_d = S_PAD;
        end
      end
      S_PAD: begin
        if (at_last_addr) state_d = S_FULL;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    hdr_cnt_d    = hdr_cnt_q;
    wr_addr_d    = wr_addr_q;
    last_buf_d   = last_buf_q;
    rate_d       = rate_q;
    chan_d       = chan_q;
    info_valid_d = info_valid_q;
    hdr_err_d    = hdr_err_q;
    we_d         = 1'b0;
    sel_d        = sel_q;
    addr_d       = addr_q;
    data_d       = data_q;
    ack_d        = 1'b0;
    filled_d     = filled_q;
    done_d       = done_q;
    ready_d      = (state_d == S_HEADER) || (state_d == S_FILL);

    case (state_q)
      S_HEADER: begin
        if (accept) begin
          hdr_cnt_d = hdr_cnt_q + 6'd1;
          if (hdr_cnt_q == 6'd22) chan_d = src_data_i;
          if (hdr_cnt_q >= 6'd24 && hdr_cnt_q <= 6'd27)
            rate_d[{hdr_cnt_q[1:0], 3'b000} +: 8] = src_data_i;
          if (state_d == S_ERROR)           hdr_err_d    = 1'b1;
          else if (state_d == S_WAIT_EMPTY) info_valid_d = 1'b1;
        end
      end
      S_WAIT_EMPTY, S_FULL: begin
        // filled follows the final write of the half by one cycle, whether data or pad.
        if (state_q == S_FULL && we_q && addr_q == LAST_ADDR) filled_d = 1'b1;
        if (respond) begin
          ack_d     = 1'b1;
          filled_d  = 1'b0;
          sel_d     = ~sel_q;
          wr_addr_d = '0;
          addr_d    = '0;
          if (last_buf_q) done_d = 1'b1;
        end
      end
      S_FILL: begin
        if (accept) begin
          we_d   = 1'b1;
          data_d = src_data_i;
          addr_d = wr_addr_q;
          if (!at_last_addr) wr_addr_d = wr_addr_q + ADDR_ONE;
          if (src_last_i)    last_buf_d = 1'b1;
        end
      end
      S_PAD: begin
        we_d   = 1'b1;
        data_d = 8'h00;
        addr_d = wr_addr_q;
        if (!at_last_addr) wr_addr_d = wr_addr_q + ADDR_ONE;
      end
      default: ;
    endcase
  end

  assign src_ready_o               = ready_q;
  assign wav_info_sampling_rate_o  = rate_q;
  assign wav_info_audio_channels_o = chan_q;
  assign wav_info_valid_o          = info_valid_q;
  assign wav_header_error_o        = hdr_err_q;
  assign fill_buffer_we_o          = we_q;
  assign fill_buffer_sel_o         = sel_q;
  assign fill_buffer_addr_o        = addr_q;
  assign fill_buffer_data_o        = data_q;
  assign codec_buffer_empty_ack_o  = ack_q;
  assign codec_buffer_filled_o     = filled_q;
  assign play_done_o               = done_q;

endmodule

// File: tb/tb_wav_buffer_filler.sv
// Directed bench for wav_buffer_filler: expected RAM writes are queued as bytes are driven
// and popped by a write monitor; control outputs are checked at fixed points.
module tb_wav_buffer_filler;
  localparam int BUF = 512;
  localparam int AW  = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    src_data_i;
  logic          src_valid_i;
  logic          src_last_i;
  logic          src_ready_o;
  logic [31:0]   wav_info_sampling_rate_o;
  logic [7:0]    wav_info_audio_channels_o;
  logic          wav_info_valid_o;
  logic          wav_header_error_o;
  logic          fill_buffer_we_o;
  logic          fill_buffer_sel_o;
  logic [AW-1:0] fill_buffer_addr_o;
  logic [7:0]    fill_buffer_data_o;
  logic          codec_buffer_empty_i;
  logic          codec_buffer_empty_ack_o;
  logic          codec_buffer_filled_o;
  logic          play_done_o;

  always #5 clk = ~clk;

  wav_buffer_filler #(
    .BUFFER_SIZE_BYTES(BUF),
    .BUFFER_ADDR_BITS (AW),
    .HEADER_BYTES     (44)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .src_data_i               (src_data_i),
    .src_valid_i              (src_valid_i),
    .src_last_i               (src_last_i),
    .src_ready_o              (src_ready_o),
    .wav_info_sampling_rate_o (wav_info_sampling_rate_o),
    .wav_info_audio_channels_o(wav_info_audio_channels_o),
    .wav_info_valid_o         (wav_info_valid_o),
    .wav_header_error_o       (wav_header_error_o),
    .fill_buffer_we_o         (fill_buffer_we_o),
    .fill_buffer_sel_o        (fill_buffer_sel_o),
    .fill_buffer_addr_o       (fill_buffer_addr_o),
    .fill_buffer_data_o       (fill_buffer_data_o),
    .codec_buffer_empty_i     (codec_buffer_empty_i),
    .codec_buffer_empty_ack_o (codec_buffer_empty_ack_o),
    .codec_buffer_filled_o    (codec_buffer_filled_o),
    .play_done_o              (play_done_o)
  );

  typedef struct packed {
    logic          sel;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t        sb[$];
  wr_t        exp_wr;
  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] hdr [44];
  logic       exp_sel;
  int         exp_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every RAM write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (fill_buffer_we_o === 1'b1) begin
      check("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_wr = sb.pop_front();
        check("write", {14'd0, fill_buffer_sel_o, fill_buffer_addr_o, fill_buffer_data_o},
              {14'd0, exp_wr});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1;
    src_valid_i = 1'b0;
    src_last_i = 1'b0;
    codec_buffer_empty_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_sel = 1'b0;
    exp_addr = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rate"}, wav_info_sampling_rate_o, 32'd0);
    check({tag, "_ctrl"}, 32'({wav_info_audio_channels_o, wav_info_valid_o, wav_header_error_o,
                               fill_buffer_we_o, fill_buffer_sel_o, codec_buffer_empty_ack_o,
                               codec_buffer_filled_o, play_done_o, src_ready_o}), 32'd0);
    check({tag, "_wr"}, 32'({fill_buffer_addr_o, fill_buffer_data_o}), 32'd0);
  endtask

  task automatic build_header(input logic [31:0] rate, input logic [7:0] ch, input logic [7:0] bits);
    logic [31:0] brate;
    brate = rate * 32'(ch) * 32'd2;
    for (int i = 0; i < 44; i++) hdr[i] = 8'h00;
    hdr[0] = 8'h52; hdr[1] = 8'h49; hdr[2] = 8'h46; hdr[3] = 8'h46;
    hdr[4] = 8'h24; hdr[5] = 8'h10;
    hdr[8] = 8'h57; hdr[9] = 8'h41; hdr[10] = 8'h56; hdr[11] = 8'h45;
    hdr[12] = 8'h66; hdr[13] = 8'h6d; hdr[14] = 8'h74; hdr[15] = 8'h20;
    hdr[16] = 8'd16; hdr[20] = 8'd1; hdr[22] = ch;
    for (int i = 0; i < 4; i++) begin
      hdr[24 + i] = rate[8*i +: 8];
      hdr[28 + i] = brate[8*i +: 8];
    end
    hdr[32] = 8'(ch * 8'd2); hdr[34] = bits;
    hdr[36] = 8'h64; hdr[37] = 8'h61; hdr[38] = 8'h74; hdr[39] = 8'h61;
    hdr[41] = 8'h10;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int waited;
    waited = 0;
    src_valid_i = 1'b1;
    src_data_i = b;
    src_last_i = last;
    @(negedge clk);
    while (src_ready_o !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (src_ready_o !== 1'b1) begin
      check("ready_timeout", 32'(src_ready_o), 32'd1);
      src_valid_i = 1'b0;
      src_last_i = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      src_valid_i = 1'b0;
      src_last_i = 1'b0;
    end
  endtask

  task automatic send_header();
    for (int i = 0; i < 44; i++) begin
      if (i == 43) check("info_valid_early", 32'(wav_info_valid_o), 32'd0);
      send_byte(hdr[i], 1'b0);
    end
  endtask

  task automatic send_pcm(input int n, input logic last_at_end, input int seed);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'((i * 13 + seed) & 255);
      sb.push_back({exp_sel, AW'(exp_addr), b});
      exp_addr++;
      send_byte(b, last_at_end && (i == n - 1));
    end
  endtask

  task automatic expect_filled_next(input string tag);
    check({tag, "_filled_early"}, 32'(codec_buffer_filled_o), 32'd0);
    check({tag, "_ready_low"}, 32'(src_ready_o), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_filled"}, 32'(codec_buffer_filled_o), 32'd1);
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_empty(input int hold, input logic exp_done);
    int acks;
    acks = 0;
    exp_sel = ~exp_sel;
    exp_addr = 0;
    codec_buffer_empty_i = 1'b1;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (codec_buffer_empty_ack_o === 1'b1) acks++;
    end
    codec_buffer_empty_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (codec_buffer_empty_ack_o === 1'b1) acks++;
    end
    check("ack_count", 32'(acks), 32'd1);
    check("sel", 32'(fill_buffer_sel_o), 32'(exp_sel));
    check("filled_cleared", 32'(codec_buffer_filled_o), 32'd0);
    check("play_done", 32'(play_done_o), 32'(exp_done));
    check("ready_after_ack", 32'(src_ready_o), 32'(!exp_done));
  endtask

  initial begin
    src_data_i = 8'h00;
    exp_sel = 1'b0;
    exp_addr = 0;
    apply_reset();
    check_zero("reset");

    // Stereo 44100: two full halves, file ends exactly at the end of the second.
    build_header(32'd44100, 8'd2, 8'd16);
    send_header();
    check("info_valid", 32'(wav_info_valid_o), 32'd1);
    check("rate", wav_info_sampling_rate_o, 32'h0000AC44);
    check("channels", 32'(wav_info_audio_channels_o), 32'd2);
    check("hdr_err_clean", 32'(wav_header_error_o), 32'd0);
    do_empty(3, 1'b0);
    send_pcm(BUF, 1'b0, 3);
    expect_filled_next("half1");
    do_empty(2, 1'b0);
    send_pcm(BUF, 1'b1, 91);
    expect_filled_next("half0_last");
    do_empty(2, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("done_held", 32'({play_done_o, codec_buffer_filled_o, codec_buffer_empty_ack_o}), 32'b100);

    // 8-bit samples: rejected at byte 34, then the stream is never consumed.
    apply_reset();
    build_header(32'd44100, 8'd2, 8'd8);
    for (int i = 0; i < 34; i++) send_byte(hdr[i], 1'b0);
    check("err_before_34", 32'(wav_header_error_o), 32'd0);
    send_byte(hdr[34], 1'b0);
    check("err_after_34", 32'(wav_header_error_o), 32'd1);
    begin
      int ready_seen;
      int acks;
      ready_seen = 0;
      acks = 0;
      src_valid_i = 1'b1;
      src_data_i = hdr[35];
      codec_buffer_empty_i = 1'b1;
      repeat (100) begin
        @(negedge clk);
        if (src_ready_o !== 1'b0) ready_seen++;
        if (codec_buffer_empty_ack_o !== 1'b0) acks++;
      end
      src_valid_i = 1'b0;
      codec_buffer_empty_i = 1'b0;
      check("err_ready_seen", 32'(ready_seen), 32'd0);
      check("err_acks", 32'(acks), 32'd0);
    end
    check("err_sticky", 32'({wav_header_error_o, wav_info_valid_o}), 32'b10);

    // Mono 8000: file ends after 300 bytes, rest of the half padded with zeros.
    apply_reset();
    build_header(32'd8000, 8'd1, 8'd16);
    send_header();
    check("rate_8k", wav_info_sampling_rate_o, 32'd8000);
    check("channels_1", 32'(wav_info_audio_channels_o), 32'd1);
    do_empty(2, 1'b0);
    send_pcm(300, 1'b1, 17);
    for (int a = 300; a < BUF; a++) sb.push_back({exp_sel, AW'(a), 8'h00});
    begin
      int waited;
      waited = 0;
      while (codec_buffer_filled_o !== 1'b1 && waited < 1000) begin
        @(posedge clk);
        #1;
        waited++;
      end
      check("pad_filled", 32'(codec_buffer_filled_o), 32'd1);
    end
    check("pad_drained", 32'(sb.size()), 32'd0);
    do_empty(2, 1'b1);

    // Reset mid-fill, then a fresh header must parse cleanly.
    apply_reset();
    build_header(32'd22050, 8'd2, 8'd16);
    send_header();
    do_empty(2, 1'b0);
    send_pcm(200, 1'b0, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_sel = 1'b0;
    exp_addr = 0;
    check_zero("midfill");
    build_header(32'd48000, 8'd1, 8'd16);
    send_header();
    check("reparse_valid", 32'(wav_info_valid_o), 32'd1);
    check("reparse_rate", wav_info_sampling_rate_o, 32'h0000BB80);
    check("reparse_channels", 32'(wav_info_audio_channels_o), 32'd1);
    do_empty(2, 1'b0);
    check("final_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wav_buffer_filler.md
Name: wav_buffer_filler

Overview:
Upstream producer for the audio codec stage. It consumes the raw WAV file byte stream from the storage reader, parses and validates the 44-byte canonical header, and publishes sampling rate and channel count on the wav_info bus. It then writes PCM bytes into the ping-pong sample RAM, one half at a time, using the empty/empty_ack/filled handshake that the codec stage consumes.

Parameters:
BUFFER_SIZE_BYTES, 512, bytes per ping-pong half.
BUFFER_ADDR_BITS, 9, width of the buffer address; equals clog2(BUFFER_SIZE_BYTES).
HEADER_BYTES, 44, header length; the data chunk starts at this byte offset.

Ports:
clk  in  1  system clock.
rst  in  1  reset: synchronous, active-high.
src_data_i  in  8  file byte.
src_valid_i  in  1  src_data_i is valid.
src_last_i  in  1  qualifies the final byte of the file; sampled only on a transfer.
src_ready_o  out  1  block accepts a byte. A transfer occurs when valid && ready.
wav_info_sampling_rate_o  out  32  little-endian header bytes 24..27.
wav_info_audio_channels_o  out  8  header byte 22.
wav_info_valid_o  out  1  header parsed and accepted; held high until reset.
wav_header_error_o  out  1  sticky header rejection flag.
fill_buffer_we_o  out  1  RAM write strobe.
fill_buffer_sel_o  out  1  RAM half being written.
fill_buffer_addr_o  out  BUFFER_ADDR_BITS  RAM write address.
fill_buffer_data_o  out  8  RAM write data.
codec_buffer_empty_i  in  1  codec has released a half and requests a fill.
codec_buffer_empty_ack_o  out  1  one-cycle acknowledge of the empty request.
codec_buffer_filled_o  out  1  a filled half is waiting for the codec.
play_done_o  out  1  codec has taken the final buffer; held high until reset.

Behaviour:
- Reset values: every output is 0. The internal byte counter, write-select register and last-buffer flag are also 0.
- All outputs are registered.
- FSM states: HEADER, WAIT_EMPTY, FILL, PAD, FULL, DONE, ERROR.
- HEADER:
  - src_ready_o=1. A byte counter counts from 0 to 43.
  - Bytes 0..3 must equal "RIFF" and bytes 8..11 must equal "WAVE".
  - Byte 22 is the channel count and must be 1 or 2. Byte 23 must be 0.
  - Bytes 24..27 are captured little-endian into the sampling rate.
  - Bytes 34..35 (bits per sample) must equal 16 (0x10, 0x00).
  - Any check failure, or src_last_i asserted during the header, goes to ERROR.
  - After byte 43 is accepted: wav_info_valid_o=1 on the next cycle, then go to WAIT_EMPTY.
- ERROR: src_ready_o=0, wav_header_error_o=1. The block stays here until rst. No RAM writes, no handshake activity.
- Handshake:
  - When codec_buffer_empty_i=1 in WAIT_EMPTY or FULL, the block does all of the following in one cycle:
    - pulses codec_buffer_empty_ack_o for exactly 1 cycle;
    - clears codec_buffer_filled_o;
    - toggles fill_buffer_sel_o;
    - clears the address to 0.
  - It then goes to FILL. If the last-buffer flag is set, it goes to DONE instead.
  - empty_i is ignored in every other state. This guarantees one ack per request, even though empty_i stays high for one cycle after the ack.
  - The first fill therefore writes half 1, which is the half the codec selects after its first toggle.
- FILL:
  - src_ready_o=1.
  - Each accepted byte appears one cycle later on fill_buffer_we_o=1, with data_o=byte and addr_o=current address. The address then increments.
- End of a half:
  - After the write at address BUFFER_SIZE_BYTES-1, codec_buffer_filled_o=1 on the next cycle and the block goes to FULL with src_ready_o=0.
- End of file:
  - An accepted byte with src_last_i=1 sets the last-buffer flag.
  - If that byte is not at address BUFFER_SIZE_BYTES-1, the block goes to PAD.
  - PAD writes 0x00 to every remaining address, one per cycle, with src_ready_o=0. It then asserts filled and goes to FULL.
  - If the last byte lands exactly at BUFFER_SIZE_BYTES-1, there is no PAD.
- DONE: play_done_o=1, filled=0, src_ready_o=0, no further acks.
- The address never wraps inside a fill. The counter compares against BUFFER_SIZE_BYTES-1 before incrementing.
- A valid byte presented while src_ready_o=0 is not consumed.
- Reset asserted mid-fill returns the block to HEADER with all outputs at 0. The partially written half is abandoned; no filled pulse is produced.

Test Plan:
- Valid stereo header (rate 44100 = 0x0000AC44, channels 2), then 1024 PCM bytes -> wav_info_valid_o=1, rate=44100, channels=2. Half 1 is written with addr 0..511, then filled=1. After empty/ack, half 0 is written.
- Header with bits per sample = 8 -> wav_header_error_o=1 after byte 34. src_ready_o stays 0 and no we pulses occur, even while valid is held high for 100 cycles.
- empty_i held high for 3 cycles in WAIT_EMPTY -> exactly one ack pulse, sel toggles once, FILL starts.
- File ends after 300 data bytes -> addresses 300..511 are written with 0x00, then filled=1. After the next empty_i: ack pulse, play_done_o=1, filled remains 0.
- File ends exactly at byte 511 of a half -> no PAD writes, filled=1 on the cycle after the final write, then DONE after the next empty_i.
- rst=1 for 1 cycle at address 200 of a fill -> all outputs are 0 on the next cycle. A fresh header is then re-parsed correctly.
